// File: rtl/ddr2_cmd_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_cmd_monitor_if
// Description : DDR2 command/address bus as seen by a passive monitor.
//               master : whoever drives the bus (controller / testbench)
//               slave  : the monitor, which only samples it
// Signals     : cke    clock enable
//               cs_n   per-rank chip select, active low
//               ras_n, cas_n, we_n  command
//               ba     bank address
//               addr   row/column/mode address (addr[10] = AP / precharge-all)
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr2_cmd_monitor_if #(
  parameter int NUM_RANKS  = 2,
  parameter int BA_WIDTH   = 3,
  parameter int ADDR_WIDTH = 14
);
  logic                  cke;
  logic [NUM_RANKS-1:0]  cs_n;
  logic                  ras_n;
  logic                  cas_n;
  logic                  we_n;
  logic [BA_WIDTH-1:0]   ba;
  logic [ADDR_WIDTH-1:0] addr;

  modport master (output cke, cs_n, ras_n, cas_n, we_n, ba, addr);
  modport slave  (input  cke, cs_n, ras_n, cas_n, we_n, ba, addr);
endinterface
`default_nettype wire

// File: rtl/ddr2_cmd_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_cmd_monitor
// Description : Passive DDR2 command-bus protocol monitor. Decodes commands,
//               tracks per-rank/per-bank open state and gap timers, shadows
//               MR/EMR1 per rank and reports the highest-priority violation.
// Ports       : ck, rst      clock, asynchronous active-high reset
//               bus          command/address bus (slave modport, input only)
//               bank_open    open flag per bank, index rank*NUM_BANKS+bank
//               mr_shadow    last MRS (ba=0) value per rank
//               emr1_shadow  last EMRS1 (ba=1) value per rank
//               err_valid    one-cycle pulse per violation
//               err_code/err_rank/err_bank  held details of last violation
//               err_count    saturating violation counter
// Revision    : 1.0 - initial release
// ============================================================================
module ddr2_cmd_monitor #(
  parameter int NUM_RANKS  = 2,
  parameter int BA_WIDTH   = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int T_RCD      = 4,
  parameter int T_RP       = 4,
  parameter int T_RAS      = 12,
  parameter int T_RFC      = 51,
  parameter int T_MRD      = 2
) (
  input  logic                                ck,
  input  logic                                rst,
  ddr2_cmd_monitor_if.slave                   bus,
  output logic [NUM_RANKS*(2**BA_WIDTH)-1:0]  bank_open,
  output logic [NUM_RANKS*ADDR_WIDTH-1:0]     mr_shadow,
  output logic [NUM_RANKS*ADDR_WIDTH-1:0]     emr1_shadow,
  output logic                                err_valid,
  output logic [3:0]                          err_code,
  output logic [1:0]                          err_rank,
  output logic [BA_WIDTH-1:0]                 err_bank,
  output logic [15:0]                         err_count
);
  localparam int NUM_BANKS = 2**BA_WIDTH;
  localparam int NUM_TOTAL = NUM_RANKS*NUM_BANKS;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_BST = 3'b110;

  // A timer holds (edges since last clear) - 1, so the gap to the command
  // being sampled now is timer+1. Saturation at 255 keeps old events "far".
  logic [7:0]           bank_tmr [NUM_TOTAL];
  logic [7:0]           rank_tmr [NUM_RANKS];
  logic [NUM_RANKS-1:0] rank_mrs;   // rank timer last cleared by MRS (else REF)

  logic [2:0]          cmd;
  logic [2:0]          n_low;
  logic [1:0]          rank_sel;
  logic                decode;
  logic                multi;
  logic                cmd_ok;
  logic                sel_open;
  logic [7:0]          sel_btmr;
  logic [7:0]          sel_rtmr;
  logic                sel_mrs;
  logic                any_open;
  logic                pall_hit;
  logic [BA_WIDTH-1:0] pall_bank;
  logic [3:0]          next_code;
  logic [BA_WIDTH-1:0] next_bank;

  function automatic logic too_soon(input logic [7:0] tmr, input int limit);
    return (int'(tmr) + 1) < limit;
  endfunction

  assign cmd    = {bus.ras_n, bus.cas_n, bus.we_n};
  assign decode = bus.cke && (n_low == 3'd1);
  assign multi  = bus.cke && (n_low > 3'd1);
  // The undefined BST encoding is treated like a NOP: no checks, no update.
  assign cmd_ok = decode && (cmd != CMD_NOP) && (cmd != CMD_BST);

  always_comb begin
    n_low    = '0;
    rank_sel = '0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      if (!bus.cs_n[r]) begin
        n_low    = n_low + 3'd1;
        rank_sel = 2'(r);
      end
    end
  end

  // Gather the addressed rank's state; precharge-all scans banks upward so
  // the first violating bank found is the lowest-numbered one.
  always_comb begin
    sel_open  = 1'b0;
    sel_btmr  = '0;
    sel_rtmr  = '0;
    sel_mrs   = 1'b0;
    any_open  = 1'b0;
    pall_hit  = 1'b0;
    pall_bank = '0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      if (2'(r) == rank_sel) begin
        sel_rtmr = rank_tmr[r];
        sel_mrs  = rank_mrs[r];
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (bank_open[r*NUM_BANKS+b]) begin
            any_open = 1'b1;
            if (!pall_hit && too_soon(bank_tmr[r*NUM_BANKS+b], T_RAS)) begin
              pall_hit  = 1'b1;
              pall_bank = BA_WIDTH'(b);
            end
          end
          if (BA_WIDTH'(b) == bus.ba) begin
            sel_open = bank_open[r*NUM_BANKS+b];
            sel_btmr = bank_tmr[r*NUM_BANKS+b];
          end
        end
      end
    end
  end

  // Violation priority: 1, 9, 7, then the per-command checks.
  always_comb begin
    next_code = 4'd0;
    next_bank = '0;
    if (multi) begin
      next_code = 4'd1;
    end else if (cmd_ok) begin
      if (sel_mrs && too_soon(sel_rtmr, T_MRD)) begin
        next_code = 4'd9;
      end else if (!sel_mrs && too_soon(sel_rtmr, T_RFC)) begin
        next_code = 4'd7;
      end else begin
        case (cmd)
          CMD_ACT: begin
            if (sel_open) begin
              next_code = 4'd2;
              next_bank = bus.ba;
            end else if (too_soon(sel_btmr, T_RP)) begin
              next_code = 4'd5;
              next_bank = bus.ba;
            end
          end
          CMD_RD, CMD_WR: begin
            if (!sel_open) begin
              next_code = 4'd3;
              next_bank = bus.ba;
            end else if (too_soon(sel_btmr, T_RCD)) begin
              next_code = 4'd4;
              next_bank = bus.ba;
            end
          end
          CMD_PRE: begin
            if (bus.addr[10]) begin
              if (pall_hit) begin
                next_code = 4'd6;
                next_bank = pall_bank;
              end
            end else if (sel_open && too_soon(sel_btmr, T_RAS)) begin
              next_code = 4'd6;
              next_bank = bus.ba;
            end
          end
          CMD_REF, CMD_MRS: begin
            if (any_open) next_code = 4'd8;
          end
          default: next_code = 4'd0;
        endcase
      end
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      bank_open <= '0;
      for (int i = 0; i < NUM_TOTAL; i++) bank_tmr[i] <= 8'hFF;
      for (int r = 0; r < NUM_RANKS; r++) rank_tmr[r] <= 8'hFF;
      rank_mrs    <= '0;
      mr_shadow   <= '0;
      emr1_shadow <= '0;
      err_valid   <= 1'b0;
      err_code    <= '0;
      err_rank    <= '0;
      err_bank    <= '0;
      err_count   <= '0;
    end else begin
      // Free-running saturating timers; clears below take precedence.
      for (int i = 0; i < NUM_TOTAL; i++) begin
        if (bank_tmr[i] != 8'hFF) bank_tmr[i] <= bank_tmr[i] + 8'd1;
      end
      for (int r = 0; r < NUM_RANKS; r++) begin
        if (rank_tmr[r] != 8'hFF) rank_tmr[r] <= rank_tmr[r] + 8'd1;
      end

      // State follows the command even when it was flagged.
      if (cmd_ok) begin
        for (int r = 0; r < NUM_RANKS; r++) begin
          if (2'(r) == rank_sel) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
              if ((cmd == CMD_ACT) && (BA_WIDTH'(b) == bus.ba)) begin
                bank_open[r*NUM_BANKS+b] <= 1'b1;
                bank_tmr[r*NUM_BANKS+b]  <= '0;
              end
              // Auto-precharge acts as a PRE at the command edge.
              if (((cmd == CMD_PRE) && ((BA_WIDTH'(b) == bus.ba) || bus.addr[10])) ||
                  (((cmd == CMD_RD) || (cmd == CMD_WR)) && bus.addr[10] &&
                   (BA_WIDTH'(b) == bus.ba))) begin
                bank_open[r*NUM_BANKS+b] <= 1'b0;
                bank_tmr[r*NUM_BANKS+b]  <= '0;
              end
            end
            if ((cmd == CMD_REF) || (cmd == CMD_MRS)) begin
              rank_tmr[r] <= '0;
              rank_mrs[r] <= (cmd == CMD_MRS);
            end
            if ((cmd == CMD_MRS) && (bus.ba == '0))
              mr_shadow[r*ADDR_WIDTH +: ADDR_WIDTH] <= bus.addr;
            if ((cmd == CMD_MRS) && (bus.ba == BA_WIDTH'(1)))
              emr1_shadow[r*ADDR_WIDTH +: ADDR_WIDTH] <= bus.addr;
          end
        end
      end

      err_valid <= (next_code != 4'd0);
      if (next_code != 4'd0) begin
        err_code <= next_code;
        err_rank <= multi ? 2'd0 : rank_sel;
        err_bank <= next_bank;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ddr2_cmd_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr2_cmd_monitor
// Description : Scoreboard bench for ddr2_cmd_monitor. The driver issues one
//               command per cycle and a timestamp-based reference model pushes
//               the expected response; a monitor pops and compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr2_cmd_monitor;
  localparam int NR = 2, BW = 3, AW = 14, NB = 8;
  localparam int T_RCD = 4, T_RP = 4, T_RAS = 12, T_RFC = 51, T_MRD = 2;
  localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100;
  localparam logic [2:0] PRE = 3'b010, REF = 3'b001, MRS = 3'b000;

  logic ck = 1'b0;
  logic rst = 1'b1;
  logic [NR*NB-1:0] bank_open;
  logic [NR*AW-1:0] mr_shadow, emr1_shadow;
  logic             err_valid;
  logic [3:0]       err_code;
  logic [1:0]       err_rank;
  logic [BW-1:0]    err_bank;
  logic [15:0]      err_count;

  ddr2_cmd_monitor_if #(.NUM_RANKS(NR), .BA_WIDTH(BW), .ADDR_WIDTH(AW)) bif ();

  ddr2_cmd_monitor #(
    .NUM_RANKS(NR), .BA_WIDTH(BW), .ADDR_WIDTH(AW),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_RFC(T_RFC), .T_MRD(T_MRD)
  ) dut (
    .ck(ck), .rst(rst), .bus(bif),
    .bank_open(bank_open), .mr_shadow(mr_shadow), .emr1_shadow(emr1_shadow),
    .err_valid(err_valid), .err_code(err_code), .err_rank(err_rank),
    .err_bank(err_bank), .err_count(err_count)
  );

  always #5 ck = ~ck;

  int edge_n = 0;
  always @(posedge ck) edge_n <= edge_n + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int               due;
    bit               v;
    logic [3:0]       code;
    logic [1:0]       rank;
    logic [BW-1:0]    bank;
    logic [15:0]      cnt;
    logic [NR*NB-1:0] open;
    logic [NR*AW-1:0] mr;
    logic [NR*AW-1:0] emr;
  } rec_t;
  rec_t sb[$];

  // Reference model: edge timestamps of the last events instead of counters.
  bit          m_open [NR][NB];
  int          m_bt   [NR][NB];   // last ACT or PRE edge per bank
  int          m_rt   [NR];       // last REF or MRS edge per rank
  bit          m_mrs  [NR];       // last rank event was MRS
  logic [AW-1:0] m_mr [NR];
  logic [AW-1:0] m_emr[NR];
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      for (int b = 0; b < NB; b++) begin
        m_open[r][b] = 1'b0;
        m_bt[r][b]   = edge_n - 1000;
      end
      m_rt[r]  = edge_n - 1000;
      m_mrs[r] = 1'b0;
      m_mr[r]  = '0;
      m_emr[r] = '0;
    end
    m_cnt = 0;
  endtask

  task automatic model_step(input bit cke, input logic [NR-1:0] cs, input logic [2:0] c,
                            input logic [BW-1:0] ba, input logic [AW-1:0] a, input int now);
    rec_t e;
    int nlow, rk, code, eb, gr, gb;
    nlow = 0; rk = 0; code = 0; eb = 0;
    for (int r = 0; r < NR; r++) if (cs[r] == 1'b0) begin nlow++; rk = r; end
    if (cke && nlow > 1) begin
      code = 1;
      rk   = 0;
    end else if (cke && nlow == 1 && c != NOP && c != 3'b110) begin
      gr = now - m_rt[rk];
      gb = now - m_bt[rk][ba];
      eb = int'(ba);
      if (m_mrs[rk] && gr < T_MRD) begin code = 9; eb = 0; end
      else if (!m_mrs[rk] && gr < T_RFC) begin code = 7; eb = 0; end
      else if (c == ACT) begin
        if (m_open[rk][ba]) code = 2;
        else if (gb < T_RP) code = 5;
      end else if (c == RD || c == WR) begin
        if (!m_open[rk][ba]) code = 3;
        else if (gb < T_RCD) code = 4;
      end else if (c == PRE) begin
        if (a[10]) begin
          for (int b = NB - 1; b >= 0; b--)
            if (m_open[rk][b] && (now - m_bt[rk][b]) < T_RAS) begin code = 6; eb = b; end
        end else if (m_open[rk][ba] && gb < T_RAS) code = 6;
      end else begin
        eb = 0;
        for (int b = 0; b < NB; b++) if (m_open[rk][b]) code = 8;
      end
      case (c)
        ACT: begin m_open[rk][ba] = 1'b1; m_bt[rk][ba] = now; end
        PRE: begin
          for (int b = 0; b < NB; b++)
            if (a[10] || b == int'(ba)) begin m_open[rk][b] = 1'b0; m_bt[rk][b] = now; end
        end
        RD, WR: if (a[10]) begin m_open[rk][ba] = 1'b0; m_bt[rk][ba] = now; end
        REF: begin m_rt[rk] = now; m_mrs[rk] = 1'b0; end
        MRS: begin
          m_rt[rk] = now; m_mrs[rk] = 1'b1;
          if (ba == 0) m_mr[rk] = a;
          if (ba == 1) m_emr[rk] = a;
        end
        default: ;
      endcase
    end
    if (code != 0 && m_cnt < 65535) m_cnt++;
    e.due = now; e.v = (code != 0); e.code = 4'(code); e.rank = 2'(rk);
    e.bank = BW'(eb); e.cnt = 16'(m_cnt);
    for (int r = 0; r < NR; r++) begin
      for (int b = 0; b < NB; b++) e.open[r*NB+b] = m_open[r][b];
      e.mr[r*AW +: AW]  = m_mr[r];
      e.emr[r*AW +: AW] = m_emr[r];
    end
    sb.push_back(e);
  endtask

  task automatic bus_idle();
    bif.cke = 1'b1; bif.cs_n = '1;
    bif.ras_n = 1'b1; bif.cas_n = 1'b1; bif.we_n = 1'b1;
    bif.ba = '0; bif.addr = '0;
  endtask

  // Drive right after an edge; the command is sampled on the next edge.
  task automatic issue(input bit cke, input logic [NR-1:0] cs, input logic [2:0] c,
                       input logic [BW-1:0] ba, input logic [AW-1:0] a);
    @(posedge ck); #1;
    bif.cke = cke; bif.cs_n = cs; {bif.ras_n, bif.cas_n, bif.we_n} = c;
    bif.ba = ba; bif.addr = a;
    model_step(cke, cs, c, ba, a, edge_n + 1);
  endtask

  task automatic cmd(input int rk, input logic [2:0] c, input int bank, input logic [AW-1:0] a);
    logic [NR-1:0] cs;
    cs = '1;
    cs[rk] = 1'b0;
    issue(1'b1, cs, c, BW'(bank), a);
  endtask

  task automatic nop(input int n);
    repeat (n) issue(1'b1, '1, NOP, '0, '0);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      int p, q;
      bit cke;
      logic [NR-1:0] cs;
      logic [2:0] c;
      logic [AW-1:0] a;
      p = $urandom_range(0, 99);
      q = $urandom_range(0, 99);
      cke = 1'b1;
      cs = '1;
      cs[$urandom_range(0, NR-1)] = 1'b0;
      if (p < 3) cs = '0;
      else if (p < 8) cke = 1'b0;
      else if (p < 12) cs = '1;
      if (q < 35) c = NOP;
      else if (q < 55) c = ACT;
      else if (q < 67) c = RD;
      else if (q < 75) c = WR;
      else if (q < 92) c = PRE;
      else if (q < 93) c = REF;
      else if (q < 96) c = MRS;
      else c = NOP;
      a = AW'($urandom);
      a[10] = ($urandom_range(0, 3) == 0);
      issue(cke, cs, c, BW'($urandom_range(0, 3)), a);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_err_valid"}, err_valid, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_err_rank"}, err_rank, 0);
    chk({tag, "_err_bank"}, err_bank, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_bank_open"}, bank_open, 0);
    chk({tag, "_mr_shadow"}, mr_shadow, 0);
    chk({tag, "_emr1_shadow"}, emr1_shadow, 0);
  endtask

  // Monitor: compare the DUT's response to the entry due on this edge.
  always @(negedge ck) begin : mon
    rec_t e;
    if (!rst && sb.size() > 0) begin
      if (sb[0].due < edge_n) begin
        chk("sb_overdue", sb[0].due, edge_n);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == edge_n) begin
        e = sb.pop_front();
        chk("err_valid", err_valid, e.v);
        if (e.v) begin
          chk("err_code", err_code, e.code);
          chk("err_rank", err_rank, e.rank);
          chk("err_bank", err_bank, e.bank);
        end
        chk("err_count", err_count, e.cnt);
        chk("bank_open", bank_open, e.open);
        chk("mr_shadow", mr_shadow, e.mr);
        chk("emr1_shadow", emr1_shadow, e.emr);
      end
    end
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_idle();
    rst = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();

    // ACT -> RD too early, then exactly at tRCD
    cmd(0, ACT, 2, 0); nop(2); cmd(0, RD, 2, 0); cmd(0, RD, 2, 0);
    // tRAS then tRP violations on rank 1 bank 5
    cmd(1, ACT, 5, 0); nop(10); cmd(1, PRE, 5, 0); nop(1); cmd(1, ACT, 5, 0);
    // mode registers and tMRD
    cmd(0, MRS, 0, 14'h0252); nop(2); cmd(0, MRS, 1, 14'h0044); cmd(0, ACT, 4, 0);
    // close everything, then tRFC boundary
    nop(20); cmd(0, PRE, 0, 14'h0400); cmd(1, PRE, 0, 14'h0400); nop(5);
    cmd(0, REF, 0, 0); nop(49); cmd(0, ACT, 1, 0); cmd(0, ACT, 2, 0);
    // precharge-all after tRAS, then REF with an open bank
    nop(20); cmd(0, PRE, 0, 14'h0400); nop(4);
    cmd(0, ACT, 0, 0); cmd(0, ACT, 3, 0); nop(12); cmd(0, PRE, 0, 14'h0400);
    nop(4); cmd(0, ACT, 0, 0); nop(12); cmd(0, REF, 0, 0);
    // cke low with a chip select asserted: no decode
    issue(1'b0, 2'b10, ACT, 3'd6, 0);
    // timers must saturate, not wrap
    nop(60); cmd(0, PRE, 1, 0); nop(256); cmd(0, ACT, 1, 0);
    cmd(1, REF, 0, 0); nop(300); cmd(1, ACT, 6, 0);

    rand_cycles(3000);

    // saturate the error counter with multi-select commands
    repeat (65600) issue(1'b1, 2'b00, ACT, 0, 0);

    // asynchronous reset mid-burst
    @(posedge ck); #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    sb.delete();
    bus_idle();
    @(posedge ck); @(posedge ck); #1;
    rst = 1'b0;
    model_reset();

    rand_cycles(800);
    nop(3);
    @(posedge ck); @(negedge ck); #1;
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
